// File: rtl/struct_field_arbiter.sv
// Round-robin arbiter that serialises a two-field packed struct from one of two
// requesters onto a narrow channel: field a beat, then field b beat.
module struct_field_arbiter #(
  parameter int unsigned WA = 1,
  parameter int unsigned WB = 2,
  parameter int unsigned CW = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req0_valid,
  input  logic [WA+WB-1:0]                    req0_data,
  output logic                                req0_ready,
  input  logic                                req1_valid,
  input  logic [WA+WB-1:0]                    req1_data,
  output logic                                req1_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [((WA > WB) ? WA : WB)-1:0]    out_data,
  output logic                                out_field,
  output logic                                out_src,
  output logic                                out_last,
  output logic [CW-1:0]                       txn_count
);

  localparam int unsigned DW = (WA > WB) ? WA : WB;
  localparam int unsigned SW = WA + WB;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  state_t          state, state_nxt;
  pair_t           cap_q, cap_nxt;
  logic            prio_q, prio_nxt;
  logic            grant0, grant1;
  logic            out_valid_nxt;
  logic [DW-1:0]   out_data_nxt;
  logic            out_field_nxt;
  logic            out_src_nxt;
  logic            out_last_nxt;
  logic [CW-1:0]   txn_nxt;

  // Ready is a one-cycle accept strobe; held off while reset is asserted.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  // State, captured struct, priority and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_q     <= '0;
      prio_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_field <= 1'b0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
      txn_count <= '0;
    end else begin
      state     <= state_nxt;
      cap_q     <= cap_nxt;
      prio_q    <= prio_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_field <= out_field_nxt;
      out_src   <= out_src_nxt;
      out_last  <= out_last_nxt;
      txn_count <= txn_nxt;
    end
  end

  // Arbitration, next state, and next values of the registered outputs.
  always_comb begin
    state_nxt     = state;
    cap_nxt       = cap_q;
    prio_nxt      = prio_q;
    out_src_nxt   = out_src;
    txn_nxt       = txn_count;
    grant0        = 1'b0;
    grant1        = 1'b0;
    out_valid_nxt = 1'b0;
    out_data_nxt  = '0;
    out_field_nxt = 1'b0;
    out_last_nxt  = 1'b0;

    case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | ~prio_q);
        grant1 = req1_valid & (~req0_valid | prio_q);
        if (grant0) begin
          cap_nxt     = pair_t'(req0_data);
          out_src_nxt = 1'b0;
          prio_nxt    = 1'b1;
          state_nxt   = SEND_A;
        end else if (grant1) begin
          cap_nxt     = pair_t'(req1_data);
          out_src_nxt = 1'b1;
          prio_nxt    = 1'b0;
          state_nxt   = SEND_A;
        end
      end
      SEND_A: begin
        if (out_ready) state_nxt = SEND_B;
      end
      SEND_B: begin
        if (out_ready) begin
          state_nxt = IDLE;
          txn_nxt   = txn_count + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Output registers track the state being entered, so a beat is valid the
    // cycle after accept and stays stable while the consumer stalls.
    case (state_nxt)
      SEND_A: begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = DW'(cap_nxt.a);
      end
      SEND_B: begin
        out_valid_nxt = 1'b1;
        out_field_nxt = 1'b1;
        out_last_nxt  = 1'b1;
        out_data_nxt  = DW'(cap_nxt.b);
      end
      default: out_src_nxt = 1'b0;
    endcase
  end

  // Struct width is fixed by the port declarations; keep it named for clarity.
  logic [SW-1:0] unused_sw;
  assign unused_sw = '0;

endmodule

// File: tb/tb_struct_field_arbiter.sv
// Directed bench for struct_field_arbiter: two instances (WA=1/WB=2/CW=16 and
// WA=5/WB=3/CW=4) with a beat scoreboard checked at the falling edge.
module tb_struct_field_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: WA=1, WB=2, CW=16
  logic        r0v, r1v, r0r, r1r, ov, ordy, of, os, ol;
  logic [2:0]  r0d, r1d;
  logic [1:0]  od;
  logic [15:0] txn;

  // Instance B: WA=5, WB=3, CW=4
  logic        s0v, s1v, s0r, s1r, sov, sordy, sof, sos, sol;
  logic [7:0]  s0d, s1d;
  logic [4:0]  sod;
  logic [3:0]  stxn;

  struct_field_arbiter #(.WA(1), .WB(2), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_field(of),
    .out_src(os), .out_last(ol), .txn_count(txn)
  );

  struct_field_arbiter #(.WA(5), .WB(3), .CW(4)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s0v), .req0_data(s0d), .req0_ready(s0r),
    .req1_valid(s1v), .req1_data(s1d), .req1_ready(s1r),
    .out_valid(sov), .out_ready(sordy), .out_data(sod), .out_field(sof),
    .out_src(sos), .out_last(sol), .txn_count(stxn)
  );

  typedef struct {
    logic [7:0] data;
    logic       field;
    logic       src;
    logic       last;
  } beat_t;

  beat_t q[$];
  beat_t q5[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic src);
    beat_t e;
    e.data = a; e.field = 1'b0; e.src = src; e.last = 1'b0; q.push_back(e);
    e.data = b; e.field = 1'b1; e.src = src; e.last = 1'b1; q.push_back(e);
  endtask

  task automatic push_a_only(input logic [7:0] a, input logic src);
    beat_t e;
    e.data = a; e.field = 1'b0; e.src = src; e.last = 1'b0; q.push_back(e);
  endtask

  task automatic push5(input logic [7:0] a, input logic [7:0] b, input logic src);
    beat_t e;
    e.data = a; e.field = 1'b0; e.src = src; e.last = 1'b0; q5.push_back(e);
    e.data = b; e.field = 1'b1; e.src = src; e.last = 1'b1; q5.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard for instance A: every accepted beat must match the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && ov && ordy) begin
      if (q.size() == 0) chk("a_beat_unexpected", 32'(q.size()), 1);
      else begin
        e = q.pop_front();
        chk("a_beat_data",  32'(od), 32'(e.data));
        chk("a_beat_field", 32'(of), 32'(e.field));
        chk("a_beat_src",   32'(os), 32'(e.src));
        chk("a_beat_last",  32'(ol), 32'(e.last));
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && sov && sordy) begin
      if (q5.size() == 0) chk("b_beat_unexpected", 32'(q5.size()), 1);
      else begin
        e = q5.pop_front();
        chk("b_beat_data",  32'(sod), 32'(e.data));
        chk("b_beat_field", 32'(sof), 32'(e.field));
        chk("b_beat_src",   32'(sos), 32'(e.src));
        chk("b_beat_last",  32'(sol), 32'(e.last));
      end
    end
  end

  initial begin
    logic [4:0] a5;
    logic [2:0] b3;

    rst_n = 1'b0;
    r0v = 1'b0; r1v = 1'b0; r0d = '0; r1d = '0; ordy = 1'b1;
    s0v = 1'b0; s1v = 1'b0; s0d = '0; s1d = '0; sordy = 1'b1;
    step(2);
    chk("rst_out_valid", 32'(ov), 0);
    chk("rst_out_data",  32'(od), 0);
    chk("rst_out_src",   32'(os), 0);
    chk("rst_out_last",  32'(ol), 0);
    chk("rst_txn",       32'(txn), 0);
    chk("rst_b_valid",   32'(sov), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single struct from req0: a=1, b=2'b10
    r0v = 1'b1; r0d = 3'b110;
    #1;
    chk("t1_ready0", 32'(r0r), 1);
    chk("t1_ready1", 32'(r1r), 0);
    push(8'h01, 8'h02, 1'b0);
    step(1);
    r0v = 1'b0;
    chk("t1_a_valid", 32'(ov), 1);
    chk("t1_a_ready0", 32'(r0r), 0);
    step(1);
    chk("t1_b_last", 32'(ol), 1);
    step(1);
    chk("t1_txn", 32'(txn), 1);
    chk("t1_idle_valid", 32'(ov), 0);
    chk("t1_idle_data", 32'(od), 0);

    // Both valid continuously after reset: grants alternate 0,1,0,1
    rst_n = 1'b0; #1; rst_n = 1'b1;
    r0v = 1'b1; r0d = 3'b101;
    r1v = 1'b1; r1d = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready0", 32'(r0r), (i % 2 == 0) ? 1 : 0);
      chk("t2_ready1", 32'(r1r), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) push(8'h01, 8'h01, 1'b0);
      else            push(8'h00, 8'h02, 1'b1);
      step(1);
      #1;
      chk("t2_busy_ready0", 32'(r0r), 0);
      chk("t2_busy_ready1", 32'(r1r), 0);
      step(1);
      #1;
      chk("t2_busy2_ready", 32'({r0r, r1r}), 0);
      step(1);
    end
    r0v = 1'b0; r1v = 1'b0;
    #1;
    chk("t2_txn", 32'(txn), 4);

    // Downstream stall during field a
    r0v = 1'b1; r0d = 3'b111;
    r1v = 1'b1; r1d = 3'b100;
    ordy = 1'b0;
    #1;
    chk("t3_ready0", 32'(r0r), 1);
    chk("t3_ready1", 32'(r1r), 0);
    push(8'h01, 8'h03, 1'b0);
    step(1);
    r0v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_valid", 32'(ov), 1);
      chk("t3_stall_data",  32'(od), 1);
      chk("t3_stall_field", 32'(of), 0);
      chk("t3_stall_ready", 32'({r0r, r1r}), 0);
      step(1);
    end
    ordy = 1'b1;
    push(8'h01, 8'h00, 1'b1);
    step(2);
    #1;
    chk("t3_ready1_after", 32'(r1r), 1);
    step(1);
    r1v = 1'b0;
    step(2);
    chk("t3_txn", 32'(txn), 6);

    // Reset in the middle of a req1 field-b beat
    r1v = 1'b1; r1d = 3'b001;
    #1;
    chk("t4_ready1", 32'(r1r), 1);
    push_a_only(8'h00, 1'b1);
    step(1);
    r1v = 1'b0;
    step(1);
    chk("t4_sendb_valid", 32'(ov), 1);
    chk("t4_sendb_last",  32'(ol), 1);
    rst_n = 1'b0;
    r0v = 1'b1; r0d = 3'b011;
    r1v = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(ov), 0);
    chk("t4_rst_last",  32'(ol), 0);
    chk("t4_rst_data",  32'(od), 0);
    chk("t4_rst_src",   32'(os), 0);
    chk("t4_rst_txn",   32'(txn), 0);
    chk("t4_rst_ready", 32'({r0r, r1r}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t4_post_ready0", 32'(r0r), 1);
    chk("t4_post_ready1", 32'(r1r), 0);
    push(8'h00, 8'h03, 1'b0);
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
    step(2);
    chk("t4_txn", 32'(txn), 1);

    // Wide instance: req1 a=5'b10011, b=3'b101
    s1v = 1'b1; s1d = 8'b10011_101;
    #1;
    chk("t5_ready1", 32'(s1r), 1);
    push5(8'b000_10011, 8'b000_00101, 1'b1);
    step(1);
    s1v = 1'b0;
    step(2);
    chk("t5_txn", 32'(stxn), 1);

    // 16 back-to-back structs on a 4-bit counter
    rst_n = 1'b0; #1; rst_n = 1'b1;
    s0v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a5 = 5'(i * 3 + 1);
      b3 = 3'(i);
      s0d = {a5, b3};
      #1;
      chk("t6_ready0", 32'(s0r), 1);
      push5(8'(a5), 8'(b3), 1'b0);
      step(3);
      if (i == 14) chk("t6_txn15", 32'(stxn), 15);
    end
    s0v = 1'b0;
    chk("t6_txn_wrap", 32'(stxn), 0);

    step(2);
    chk("drain_a", 32'(q.size()), 0);
    chk("drain_b", 32'(q5.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
